// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared types and event codes for the up/down counter
package updown_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam logic [1:0] EV_NONE = 2'd0;
    localparam logic [1:0] EV_OVF  = 2'd1;
    localparam logic [1:0] EV_UNF  = 2'd2;

endpackage

// File: rtl/ce_prescaler.sv
// rtl/ce_prescaler.sv - divides qualified ce cycles into one tick every PRESCALE hits
module ce_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = ce && !clr && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (ce) begin
            r_cnt <= w_last ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down counter with runtime limit, step, wrap/saturate and sticky flags
module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP_W   = 4,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              up_down,
    input  logic              ce,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero_flag,
    output logic              ovf_pulse,
    output logic              unf_pulse,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_ovf_pulse;
    logic             r_unf_pulse;
    logic             r_ovf_sticky;
    logic             r_unf_sticky;

    logic             w_load;
    logic             w_clamp;
    logic             w_ce_q;
    logic             w_tick;
    logic [WIDTH:0]   w_lim_x;
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next;
    logic [1:0]       w_event;
    dir_e             w_dir;
    mode_e            w_mode;

    assign w_load  = !load_n;
    assign w_clamp = load_n && (r_count > limit);
    // Load and clamp cycles must not advance the prescaler
    assign w_ce_q  = ce && load_n && !w_clamp;
    assign w_dir   = dir_e'(up_down);
    assign w_mode  = mode_e'(sat_mode);

    ce_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (w_ce_q),
        .clr   (w_load),
        .tick  (w_tick)
    );

    always_comb begin
        w_lim_x  = {1'b0, limit};
        w_cnt_x  = {1'b0, r_count};
        w_step_x = (WIDTH+1)'(step);
        w_s      = (w_step_x > w_lim_x) ? w_lim_x : w_step_x;
        w_sum    = w_cnt_x + w_s;
        w_next   = r_count;
        w_event  = EV_NONE;
        if (w_tick && (w_s != '0)) begin
            if (w_dir == DIR_UP) begin
                if (w_sum <= w_lim_x) begin
                    w_next = WIDTH'(w_sum);
                end else begin
                    w_event = EV_OVF;
                    w_next  = (w_mode == MODE_SAT) ? limit
                                                   : WIDTH'(w_sum - w_lim_x - ONE_X);
                end
            end else begin
                if (w_cnt_x >= w_s) begin
                    w_next = WIDTH'(w_cnt_x - w_s);
                end else begin
                    w_event = EV_UNF;
                    w_next  = (w_mode == MODE_SAT) ? '0
                                                   : WIDTH'(w_cnt_x + w_lim_x + ONE_X - w_s);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_ovf_pulse  <= 1'b0;
            r_unf_pulse  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            if (w_load) begin
                r_count <= (data_load > limit) ? limit : data_load;
            end else if (w_clamp) begin
                r_count <= limit;
            end else begin
                r_count <= w_next;
            end
            r_ovf_pulse <= (w_event == EV_OVF);
            r_unf_pulse <= (w_event == EV_UNF);
            // A same-cycle event overrides the clear
            if (w_event == EV_OVF) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_ovf_sticky <= 1'b0;
            end
            if (w_event == EV_UNF) begin
                r_unf_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_unf_sticky <= 1'b0;
            end
        end
    end

    assign count_out  = r_count;
    assign max_count  = (r_count == limit);
    assign zero_flag  = (r_count == '0);
    assign ovf_pulse  = r_ovf_pulse;
    assign unf_pulse  = r_unf_pulse;
    assign ovf_sticky = r_ovf_sticky;
    assign unf_sticky = r_unf_sticky;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - vector table and scoreboard bench for updown_counter_mod
module tb_updown_counter_mod;

    typedef struct {
        logic        ld_n;
        logic [15:0] dl;
        logic        ud;
        logic        ce;
        logic [3:0]  step;
        logic [15:0] lim;
        logic        sat;
        logic        clr;
        logic [15:0] cnt;
        logic        op;
        logic        up;
        logic        os;
        logic        us;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_n;
    logic [15:0] data_load;
    logic        up_down;
    logic        ce;
    logic [3:0]  step;
    logic [15:0] limit;
    logic        sat_mode;
    logic        clr_flags;

    logic [15:0] count_out, count_out3;
    logic        max_count, max_count3;
    logic        zero_flag, zero_flag3;
    logic        ovf_pulse, ovf_pulse3;
    logic        unf_pulse, unf_pulse3;
    logic        ovf_sticky, ovf_sticky3;
    logic        unf_sticky, unf_sticky3;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(16), .STEP_W(4), .PRESCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .data_load(data_load),
        .up_down(up_down), .ce(ce), .step(step), .limit(limit),
        .sat_mode(sat_mode), .clr_flags(clr_flags), .count_out(count_out),
        .max_count(max_count), .zero_flag(zero_flag), .ovf_pulse(ovf_pulse),
        .unf_pulse(unf_pulse), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    updown_counter_mod #(.WIDTH(16), .STEP_W(4), .PRESCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load_n(load_n), .data_load(data_load),
        .up_down(up_down), .ce(ce), .step(step), .limit(limit),
        .sat_mode(sat_mode), .clr_flags(clr_flags), .count_out(count_out3),
        .max_count(max_count3), .zero_flag(zero_flag3), .ovf_pulse(ovf_pulse3),
        .unf_pulse(unf_pulse3), .ovf_sticky(ovf_sticky3), .unf_sticky(unf_sticky3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ld_n, input logic [15:0] dl, input logic ud,
                                input logic c, input logic [3:0] st, input logic [15:0] lim,
                                input logic sat, input logic clr, input logic [15:0] cnt,
                                input logic op, input logic up, input logic os, input logic us);
        vec_t v;
        v.ld_n = ld_n; v.dl = dl; v.ud = ud; v.ce = c; v.step = st; v.lim = lim;
        v.sat = sat; v.clr = clr; v.cnt = cnt; v.op = op; v.up = up; v.os = os; v.us = us;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        load_n = v.ld_n; data_load = v.dl; up_down = v.ud; ce = v.ce; step = v.step;
        limit = v.lim; sat_mode = v.sat; clr_flags = v.clr;
        sb_q.push_back(v);
    endtask

    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("count_out",  32'(count_out),  32'(e.cnt));
            chk("ovf_pulse",  32'(ovf_pulse),  32'(e.op));
            chk("unf_pulse",  32'(unf_pulse),  32'(e.up));
            chk("ovf_sticky", 32'(ovf_sticky), 32'(e.os));
            chk("unf_sticky", 32'(unf_sticky), 32'(e.us));
            chk("max_count",  32'(max_count),  32'(e.cnt == e.lim));
            chk("zero_flag",  32'(zero_flag),  32'(e.cnt == 16'd0));
        end
    end

    initial begin
        int hits;
        int exp1;
        vec_t v;

        // Wrap up 0..9 with limit 9
        for (int i = 1; i <= 12; i++)
            tbl.push_back(mk(1, 0, 1, 1, 1, 9, 0, 0, 16'(i % 10), i == 10, 0, i >= 10, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 9, 0, 1, 2, 0, 0, 0, 0));
        // Saturating down, step 2
        tbl.push_back(mk(0, 3, 0, 1, 2, 255, 1, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2, 255, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2, 255, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 2, 255, 1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 2, 255, 1, 1, 0, 0, 0, 0, 0));
        // Wrapping down, step 3
        tbl.push_back(mk(0, 1, 0, 1, 3, 9, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 3, 9, 0, 0, 8, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 3, 9, 0, 0, 5, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 3, 9, 0, 0, 2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 3, 9, 0, 0, 9, 0, 1, 0, 1));
        // Load above limit, clamp on limit drop, event beats clear
        tbl.push_back(mk(0, 200, 1, 1, 1, 100, 0, 1, 100, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 50, 0, 0, 50, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 50, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 50, 0, 1, 0, 0, 0, 0, 0));
        // Step larger than limit is reduced to limit
        tbl.push_back(mk(0, 0, 1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 5, 2, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 5, 2, 0, 0, 1, 1, 0, 1, 0));
        // Limit zero holds count at 0 with no events
        tbl.push_back(mk(1, 0, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0));
        // Saturate at top, repeated events, step 0, ce low
        tbl.push_back(mk(0, 8, 1, 1, 1, 9, 1, 0, 8, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 9, 1, 0, 9, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 9, 1, 0, 9, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 9, 1, 0, 9, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 9, 1, 0, 9, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 9, 1, 0, 9, 0, 0, 1, 0));

        rst_n = 1'b0; load_n = 1'b1; data_load = '0; up_down = 1'b1; ce = 1'b0;
        step = 4'd1; limit = 16'd9; sat_mode = 1'b0; clr_flags = 1'b0;
        #12;
        chk("rst count_out", 32'(count_out), 0);
        chk("rst zero_flag", 32'(zero_flag), 1);
        chk("rst max_count lim9", 32'(max_count), 0);
        chk("rst pulses", 32'({ovf_pulse, unf_pulse}), 0);
        chk("rst sticky", 32'({ovf_sticky, unf_sticky}), 0);
        limit = 16'd0;
        #1;
        chk("rst max_count lim0", 32'(max_count), 1);
        limit = 16'd9;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // PRESCALE=3 instance: count only every third ce-high edge
        apply(mk(0, 0, 1, 1, 1, 255, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #2;
        chk("presc load count", 32'(count_out3), 0);
        hits = 0;
        exp1 = 0;
        for (int i = 0; i < 7; i++) begin
            logic c;
            c = (i != 2);
            if (c) begin
                hits++;
                exp1++;
            end
            apply(mk(1, 0, 1, c, 1, 255, 0, 0, 16'(exp1), 0, 0, 0, 0));
            @(posedge clk); #2;
            chk("presc count", 32'(count_out3), 32'(hits / 3));
        end

        // Asynchronous reset between edges while a pulse is high
        apply(mk(0, 8, 1, 1, 5, 9, 0, 0, 8, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 1, 5, 9, 0, 0, 3, 1, 0, 1, 0));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async rst count", 32'(count_out), 0);
        chk("async rst ovf_pulse", 32'(ovf_pulse), 0);
        chk("async rst ovf_sticky", 32'(ovf_sticky), 0);
        chk("async rst zero_flag", 32'(zero_flag), 1);
        @(posedge clk); #2;
        chk("held rst count", 32'(count_out), 0);
        rst_n = 1'b1;
        chk("scoreboard drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
